multiclock_reg_arbiter: RTL and testbench

MULTICLOCK_REG_ARBITER -- requirements
Module: multiclock_reg_arbiter

---
 rtl/multiclock_reg_arbiter_pkg.sv | 20 ++
 rtl/multiclock_reg_arbiter_rr_pick.sv | 33 +++
 rtl/multiclock_reg_arbiter.sv | 85 ++++++++
 tb/tb_multiclock_reg_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiclock_reg_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter: FSM encoding and
// the width helper used to size index and counter fields.
package multiclock_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Number of bits needed to encode values 0..value-1; yields 0 for value <= 1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/multiclock_reg_arbiter_rr_pick.sv
// Round-robin priority pick: scans requesters starting just after last_grant
// and returns the first active one as a one-hot vector plus its index.
module rr_pick
    import multiclock_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/multiclock_reg_arbiter.sv
// Shared register written by N_REQ requesters under round-robin arbitration;
// each accepted value is held for HOLD_CYC cycles before the next grant.
module multiclock_reg_arbiter
    import multiclock_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                      myClock,
    input  logic                      myNewReset_n,
    input  logic [N_REQ-1:0]          io_req_valid,
    input  logic [N_REQ*DATA_W-1:0]   io_req_data,
    output logic [N_REQ-1:0]          io_req_ready,
    output logic [DATA_W-1:0]         io_out,
    output logic                      io_out_valid,
    output logic [clog2(N_REQ)-1:0]   io_grant_id,
    output logic                      io_busy
);

    localparam int IDX_W = clog2(N_REQ);
    localparam int CNT_W = clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

    state_t            state;
    logic [DATA_W-1:0] shared_reg;
    logic [CNT_W-1:0]  hold_cnt;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  grant_id;
    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_index;
    logic              handshake;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (io_req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .index      (pick_index)
    );

    // Grants are offered only in IDLE and are suppressed while reset is low,
    // so a request seen in the reset cycle is never acknowledged.
    assign io_req_ready = (state == IDLE && myNewReset_n) ? pick_grant : '0;
    assign handshake    = |(io_req_valid & io_req_ready);

    always_ff @(posedge myClock) begin
        if (!myNewReset_n) begin
            state      <= IDLE;
            shared_reg <= '0;
            hold_cnt   <= '0;
            grant_id   <= '0;
            last_grant <= LAST_RESET;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        shared_reg <= io_req_data[pick_index*DATA_W +: DATA_W];
                        last_grant <= pick_index;
                        grant_id   <= pick_index;
                        hold_cnt   <= HOLD_LOAD;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io_out       = shared_reg;
    assign io_grant_id  = grant_id;
    assign io_out_valid = (state == HOLD);
    assign io_busy      = (state == HOLD);

endmodule

// File: tb/tb_multiclock_reg_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model; a second instance covers the HOLD_CYC=1 build.
module tb_multiclock_reg_arbiter;

    logic        myClock;
    logic        myNewReset_n;
    logic [3:0]  valid0, ready0;
    logic [31:0] data0;
    logic [7:0]  out0;
    logic        out_valid0, busy0;
    logic [1:0]  gid0;
    logic [3:0]  valid1, ready1;
    logic [31:0] data1;
    logic [7:0]  out1;
    logic        out_valid1, busy1;
    logic [1:0]  gid1;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the default build: value, remaining hold cycles, ids.
    logic [7:0] m_out;
    int         m_left;
    logic [1:0] m_gid;
    int         m_last;

    multiclock_reg_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(2)) u_dut (
        .myClock      (myClock),
        .myNewReset_n (myNewReset_n),
        .io_req_valid (valid0),
        .io_req_data  (data0),
        .io_req_ready (ready0),
        .io_out       (out0),
        .io_out_valid (out_valid0),
        .io_grant_id  (gid0),
        .io_busy      (busy0)
    );

    multiclock_reg_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(1)) u_dut_h1 (
        .myClock      (myClock),
        .myNewReset_n (myNewReset_n),
        .io_req_valid (valid1),
        .io_req_data  (data1),
        .io_req_ready (ready1),
        .io_out       (out1),
        .io_out_valid (out_valid1),
        .io_grant_id  (gid1),
        .io_busy      (busy1)
    );

    initial myClock = 1'b0;
    always #5 myClock = ~myClock;

    function automatic int model_winner(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        int w;
        r = 4'b0000;
        if (myNewReset_n && m_left == 0) begin
            w = model_winner(valid0, m_last);
            if (w >= 0) r[w] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_step();
        int w;
        if (!myNewReset_n) begin
            m_out = 8'h00; m_left = 0; m_gid = 2'd0; m_last = 3;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else begin
            w = model_winner(valid0, m_last);
            if (w >= 0) begin
                m_out  = data0[w*8 +: 8];
                m_gid  = w[1:0];
                m_last = w;
                m_left = 2;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic [3:0] v, input logic [31:0] d);
        myNewReset_n = rst_n;
        valid0       = v;
        data0        = d;
    endtask

    task automatic advance();
        model_step();
        @(negedge myClock);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 4'b0000, $urandom);
            #1;
            advance();
        end
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 4'b1111, $urandom);
        #1;
        n_checks++;
        if (ready0 !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready_first: got %b expected 0000", ready0); end
        advance();
        applyStimulus(1'b0, 4'b1111, $urandom);
        #1;
        n_checks += 4;
        if (ready0 !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0000", ready0); end
        if (out0 !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_out: got %h expected 00", out0); end
        if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_busy: got %b%b expected 00", out_valid0, busy0); end
        if (gid0 !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_gid: got %0d expected 0", gid0); end
        advance();
        applyStimulus(1'b1, 4'b0000, $urandom);
        #1;
        n_checks += 3;
        if (ready0 !== 4'b0000) begin n_fail++; $display("[TB] FAIL idle_ready: got %b expected 0000", ready0); end
        if (out0 !== 8'h00) begin n_fail++; $display("[TB] FAIL idle_out: got %h expected 00", out0); end
        if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_valid_busy: got %b%b expected 00", out_valid0, busy0); end
        advance();
    endtask

    task automatic test_single();
        logic [31:0] d;
        d = $urandom;
        d[23:16] = 8'hA5;
        applyStimulus(1'b1, 4'b0100, d);
        #1;
        n_checks++;
        if (ready0 !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_ready: got %b expected 0100", ready0); end
        advance();
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b1, 4'b0000, $urandom);
            #1;
            n_checks += 3;
            if (out0 !== 8'hA5) begin n_fail++; $display("[TB] FAIL single_out c%0d: got %h expected a5", c, out0); end
            if (gid0 !== 2'd2) begin n_fail++; $display("[TB] FAIL single_gid c%0d: got %0d expected 2", c, gid0); end
            if (out_valid0 !== (c < 3) || busy0 !== (c < 3)) begin
                n_fail++; $display("[TB] FAIL single_valid c%0d: got %b%b expected %b%b", c, out_valid0, busy0, c < 3, c < 3);
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        logic [7:0] gdata;
        applyStimulus(1'b0, 4'b0000, $urandom); #1; advance();
        applyStimulus(1'b0, 4'b0000, $urandom); #1; advance();
        gdata = 8'h00;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, 4'b1111, $urandom);
            #1;
            exp = (c % 3 == 0) ? (4'b0001 << (c / 3)) : 4'b0000;
            n_checks += 2;
            if (ready0 !== exp) begin n_fail++; $display("[TB] FAIL rr_ready c%0d: got %b expected %b", c, ready0, exp); end
            if (!$onehot0(ready0)) begin n_fail++; $display("[TB] FAIL rr_onehot c%0d: got %b expected one-hot or zero", c, ready0); end
            if (c % 3 == 1) begin
                n_checks += 2;
                if (gid0 !== 2'(c / 3)) begin n_fail++; $display("[TB] FAIL rr_gid c%0d: got %0d expected %0d", c, gid0, c / 3); end
                if (out0 !== gdata || out_valid0 !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL rr_out c%0d: got %h/%b expected %h/1", c, out0, out_valid0, gdata);
                end
            end
            if (c % 3 == 0) gdata = data0[(c / 3)*8 +: 8];
            advance();
        end
    endtask

    task automatic test_hold_immunity();
        logic [31:0] d;
        run_idle(3);
        d = $urandom; d[15:8] = 8'h77;
        applyStimulus(1'b1, 4'b0010, d);
        #1;
        n_checks++;
        if (ready0 !== 4'b0010) begin n_fail++; $display("[TB] FAIL imm_ready: got %b expected 0010", ready0); end
        advance();
        for (int c = 0; c < 3; c++) begin
            d = $urandom; d[15:8] = 8'h3C;
            applyStimulus(1'b1, (c < 2) ? 4'b0000 : 4'b0010, d);
            #1;
            n_checks += 2;
            if (out0 !== 8'h77) begin n_fail++; $display("[TB] FAIL imm_out c%0d: got %h expected 77", c, out0); end
            if (out_valid0 !== (c < 2)) begin n_fail++; $display("[TB] FAIL imm_valid c%0d: got %b expected %b", c, out_valid0, c < 2); end
            advance();
        end
        applyStimulus(1'b1, 4'b0000, $urandom);
        #1;
        n_checks++;
        if (out0 !== 8'h3C || gid0 !== 2'd1) begin n_fail++; $display("[TB] FAIL imm_regrant: got %h/%0d expected 3c/1", out0, gid0); end
        advance();
    endtask

    task automatic test_reset_mid_hold();
        logic [31:0] d;
        run_idle(3);
        d = $urandom; d[23:16] = 8'h5A;
        applyStimulus(1'b1, 4'b0100, d);
        #1; advance();
        applyStimulus(1'b0, 4'b0000, $urandom);
        #1;
        n_checks++;
        if (out0 !== 8'h5A || out_valid0 !== 1'b1) begin n_fail++; $display("[TB] FAIL rmh_hold: got %h/%b expected 5a/1", out0, out_valid0); end
        advance();
        d = $urandom; d[7:0] = 8'h81;
        applyStimulus(1'b1, 4'b0001, d);
        #1;
        n_checks += 2;
        if (out0 !== 8'h00 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rmh_after: got %h/%b/%b expected 00/0/0", out0, out_valid0, busy0);
        end
        if (ready0 !== 4'b0001) begin n_fail++; $display("[TB] FAIL rmh_ready: got %b expected 0001", ready0); end
        advance();
        applyStimulus(1'b1, 4'b0000, $urandom);
        #1;
        n_checks++;
        if (out0 !== 8'h81 || gid0 !== 2'd0 || out_valid0 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rmh_grant: got %h/%0d/%b expected 81/0/1", out0, gid0, out_valid0);
        end
        advance();
        run_idle(2);
    endtask

    task automatic test_random();
        logic [3:0] er;
        for (int c = 0; c < 300; c++) begin
            applyStimulus($urandom_range(0, 31) != 0, 4'($urandom_range(0, 15)), $urandom);
            #1;
            er = model_ready();
            n_checks += 5;
            if (ready0 !== er) begin n_fail++; $display("[TB] FAIL rand_ready c%0d: got %b expected %b", c, ready0, er); end
            if (out0 !== m_out) begin n_fail++; $display("[TB] FAIL rand_out c%0d: got %h expected %h", c, out0, m_out); end
            if (out_valid0 !== (m_left > 0)) begin n_fail++; $display("[TB] FAIL rand_valid c%0d: got %b expected %b", c, out_valid0, m_left > 0); end
            if (busy0 !== (m_left > 0)) begin n_fail++; $display("[TB] FAIL rand_busy c%0d: got %b expected %b", c, busy0, m_left > 0); end
            if (gid0 !== m_gid) begin n_fail++; $display("[TB] FAIL rand_gid c%0d: got %0d expected %0d", c, gid0, m_gid); end
            advance();
        end
    endtask

    task automatic test_hold1();
        logic [3:0] exp;
        logic [7:0] gdata;
        applyStimulus(1'b0, 4'b0000, $urandom); #1; advance();
        applyStimulus(1'b0, 4'b0000, $urandom); #1; advance();
        gdata = 8'h00;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 4'b0000, $urandom);
            valid1 = 4'b0011;
            data1  = $urandom;
            #1;
            exp = (c % 2 == 1) ? 4'b0000 : (((c / 2) % 2 == 0) ? 4'b0001 : 4'b0010);
            n_checks += 2;
            if (ready1 !== exp) begin n_fail++; $display("[TB] FAIL h1_ready c%0d: got %b expected %b", c, ready1, exp); end
            if (out_valid1 !== (c % 2 == 1)) begin n_fail++; $display("[TB] FAIL h1_valid c%0d: got %b expected %b", c, out_valid1, c % 2 == 1); end
            if (c % 2 == 1) begin
                n_checks++;
                if (out1 !== gdata || gid1 !== 2'(((c - 1) / 2) % 2)) begin
                    n_fail++; $display("[TB] FAIL h1_out c%0d: got %h/%0d expected %h/%0d", c, out1, gid1, gdata, ((c - 1) / 2) % 2);
                end
            end else begin
                gdata = data1[(((c / 2) % 2))*8 +: 8];
            end
            advance();
        end
        valid1 = 4'b0000;
    endtask

    initial begin
        valid1 = 4'b0000;
        data1  = 32'h0;
        applyStimulus(1'b0, 4'b0000, 32'h0);
        m_out = 8'h00; m_left = 0; m_gid = 2'd0; m_last = 3;
        @(negedge myClock);
        $display("[TB] starting multiclock_reg_arbiter bench");
        test_reset();
        test_single();
        test_round_robin();
        test_hold_immunity();
        test_reset_mid_hold();
        test_random();
        test_hold1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
